// File: rtl/a2600_bs_pkg.sv
// Shared constants for the Atari 2600 bank-switch detector.
//   - 5-bit mapper codes understood by the cart loader (BS_*)
//   - image size constants in bytes (SZ_*)
//   - bs_hit_t: one bit per opcode-signature family
package a2600_bs_pkg;

  localparam logic [4:0] BS_NONE = 5'd0;
  localparam logic [4:0] BS_F8   = 5'd1;
  localparam logic [4:0] BS_F6   = 5'd2;
  localparam logic [4:0] BS_FE   = 5'd3;
  localparam logic [4:0] BS_E0   = 5'd4;
  localparam logic [4:0] BS_3F   = 5'd5;
  localparam logic [4:0] BS_F4   = 5'd6;
  localparam logic [4:0] BS_P2   = 5'd7;
  localparam logic [4:0] BS_FA   = 5'd8;
  localparam logic [4:0] BS_CV   = 5'd9;
  localparam logic [4:0] BS_UA   = 5'd11;
  localparam logic [4:0] BS_E7   = 5'd12;
  localparam logic [4:0] BS_F0   = 5'd13;

  localparam logic [31:0] SZ_2K      = 32'd2048;
  localparam logic [31:0] SZ_4K      = 32'd4096;
  localparam logic [31:0] SZ_8K      = 32'd8192;
  localparam logic [31:0] SZ_10K     = 32'd10240;
  localparam logic [31:0] SZ_10K_DPC = 32'd10495;  // DPC image with 255B display data appended
  localparam logic [31:0] SZ_12K     = 32'd12288;
  localparam logic [31:0] SZ_16K     = 32'd16384;
  localparam logic [31:0] SZ_32K     = 32'd32768;
  localparam logic [31:0] SZ_64K     = 32'd65536;

  typedef struct packed {
    logic e0;
    logic e7;
    logic p3f;  // single "85 3F" occurrence, counted by the top
    logic ua;
    logic cv;
    logic fe;
  } bs_hit_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

endpackage

// File: rtl/bs_sig_match.sv
// Combinational opcode-signature matcher.
//   win  : last four accepted bytes, win[0] newest
//   data : byte being written this cycle (youngest byte of the match window)
//   hit  : per-scheme signature hit for the 5-byte window {win[3..0], data}
module bs_sig_match
  import a2600_bs_pkg::*;
(
  input  logic [3:0][7:0] win,
  input  logic [7:0]      data,
  output bs_hit_t         hit
);

  logic [15:0] t2;
  logic [23:0] t3;
  logic [39:0] t5;

  assign t2 = {win[0], data};
  assign t3 = {win[1], win[0], data};
  assign t5 = {win[3], win[2], win[1], win[0], data};

  always_comb begin
    hit     = '0;
    hit.e0  = t3 inside {24'h8DE01F, 24'h8DE05F, 24'h8DE9FF,
                         24'hADE9FF, 24'hADEDFF, 24'hADF3BF};
    hit.e7  = t3 inside {24'hADE2FF, 24'hADE5FF, 24'hADE51F, 24'hADE71F,
                         24'h0CE71F, 24'h8DE7FF, 24'h8DE71F};
    hit.p3f = (t2 == 16'h853F);
    hit.ua  = t3 inside {24'h8D4002, 24'hAD4002, 24'hBD1F02};
    hit.cv  = t3 inside {24'h9DFFF3, 24'h9900F4};
    hit.fe  = t5 inside {40'h2000D0C6C5, 40'h20C3F8A582,
                         40'hD0FB2073FE, 40'h2000F084D6};
  end

endmodule

// File: rtl/detect2600.sv
// Atari 2600 cartridge bank-switch scheme detector.
// Snoops the cart download stream, keeps sticky signature flags and a
// SuperChip tracker, and combines them with the image size into a mapper code.
//   clk_sys   : system clock
//   reset     : synchronous active-high clear of all detection state
//   addr      : byte address of the current download byte
//   enable    : download write strobe, byte valid
//   data      : ROM byte at addr
//   cart_size : image size in bytes, driven by the loader
//   force_bs  : detected mapper code (combinational from flags + cart_size)
//   sc        : SuperChip (128B extra RAM) present
module detect2600
  import a2600_bs_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        enable,
  input  logic [7:0]  data,
  input  logic [31:0] cart_size,
  output logic [4:0]  force_bs,
  output logic        sc
);

  // Four stored bytes plus the incoming byte form the 5-byte match window.
  logic [3:0][7:0] win;
  logic [7:0]      first_byte;
  logic            e0_f, e7_f, ua_f, cv_f, fe_f;
  logic [1:0]      cnt3f;
  logic            sc_eq;
  logic            seen255;
  bs_hit_t         hit;

  logic f3f;
  logic restart;

  assign f3f     = cnt3f[1];  // count >= 2
  assign restart = enable && (addr == 16'd0);

  bs_sig_match u_match (
    .win  (win),
    .data (data),
    .hit  (hit)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      win        <= '0;
      first_byte <= '0;
      e0_f       <= 1'b0;
      e7_f       <= 1'b0;
      ua_f       <= 1'b0;
      cv_f       <= 1'b0;
      fe_f       <= 1'b0;
      cnt3f      <= '0;
      sc_eq      <= 1'b1;
      seen255    <= 1'b0;
    end else if (restart) begin
      // New image: the window before this byte is discarded, so nothing
      // can match across the boundary.
      win        <= {24'h0, data};
      first_byte <= data;
      e0_f       <= 1'b0;
      e7_f       <= 1'b0;
      ua_f       <= 1'b0;
      cv_f       <= 1'b0;
      fe_f       <= 1'b0;
      cnt3f      <= '0;
      sc_eq      <= 1'b1;
      seen255    <= 1'b0;
    end else if (enable) begin
      win  <= {win[2:0], data};
      e0_f <= e0_f | hit.e0;
      e7_f <= e7_f | hit.e7;
      ua_f <= ua_f | hit.ua;
      cv_f <= cv_f | hit.cv;
      fe_f <= fe_f | hit.fe;
      if (hit.p3f) cnt3f <= sat_inc2(cnt3f);
      // SuperChip images mirror the RAM write area: first 256 bytes identical.
      if (addr <= 16'd255) sc_eq <= sc_eq & (data == first_byte);
      if (addr == 16'd255) seen255 <= 1'b1;
    end
  end

  assign sc = sc_eq && seen255 &&
              ((cart_size == SZ_8K) || (cart_size == SZ_16K) || (cart_size == SZ_32K));

  always_comb begin
    force_bs = BS_NONE;
    if (cart_size == SZ_2K && cv_f) begin
      force_bs = BS_CV;
    end else if (cart_size <= SZ_4K) begin
      force_bs = BS_NONE;
    end else begin
      case (cart_size)
        SZ_8K: begin
          if      (e0_f) force_bs = BS_E0;
          else if (f3f)  force_bs = BS_3F;
          else if (ua_f) force_bs = BS_UA;
          else if (fe_f) force_bs = BS_FE;
          else           force_bs = BS_F8;
        end
        SZ_10K, SZ_10K_DPC: force_bs = BS_P2;
        SZ_12K:             force_bs = BS_FA;
        SZ_16K: begin
          if      (e7_f) force_bs = BS_E7;
          else if (f3f)  force_bs = BS_3F;
          else           force_bs = BS_F6;
        end
        SZ_32K:  force_bs = f3f ? BS_3F : BS_F4;
        SZ_64K:  force_bs = f3f ? BS_3F : BS_F0;
        default: force_bs = f3f ? BS_3F : BS_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_detect2600.sv
// Self-checking bench for detect2600: table of download images plus
// hand-written restart / reset / hold sequences, checked via a scoreboard queue.
module tb_detect2600;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        enable;
  logic [7:0]  data;
  logic [31:0] cart_size;
  logic [4:0]  force_bs;
  logic        sc;

  always #5 clk_sys = ~clk_sys;

  detect2600 dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .addr      (addr),
    .enable    (enable),
    .data      (data),
    .cart_size (cart_size),
    .force_bs  (force_bs),
    .sc        (sc)
  );

  // size: cart_size; len: bytes actually streamed (result depends only on
  // flags and cart_size); fill 0=random 0x40-0x7F, 1=first 256B 0xFF,
  // 2=as 1 but byte 0x80=0x00; sig inserted reps times at at+k*0x100.
  typedef struct {
    string       name;
    int          size;
    int          len;
    int          fill;
    logic [39:0] sig;
    int          slen;
    int          at;
    int          reps;
    logic [4:0]  exp_bs;
    logic        exp_sc;
  } vec_t;

  typedef struct {
    string      name;
    logic [4:0] bs;
    logic       sc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[13];

  function automatic vec_t mk(input string n, input int size, input int len, input int fill,
                              input logic [39:0] sig, input int slen, input int at, input int reps,
                              input logic [4:0] bs, input logic s);
    vec_t v;
    v.name = n; v.size = size; v.len = len; v.fill = fill; v.sig = sig;
    v.slen = slen; v.at = at; v.reps = reps; v.exp_bs = bs; v.exp_sc = s;
    return v;
  endfunction

  function automatic logic [7:0] gen_byte(input vec_t v, input int a);
    logic [39:0] s;
    int off;
    s = v.sig;
    for (int k = 0; k < v.reps; k++) begin
      off = a - (v.at + k * 256);
      if (off >= 0 && off < v.slen) return s[39 - 8 * off -: 8];
    end
    if (v.fill == 2 && a == 128) return 8'h00;
    if (v.fill != 0 && a < 256) return 8'hFF;
    return 8'($urandom_range(8'h40, 8'h7F));
  endfunction

  task automatic drive(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    enable = 1'b1;
    addr   = a;
    data   = d;
  endtask

  task automatic idle();
    @(negedge clk_sys);
    enable = 1'b0;
  endtask

  task automatic push_exp(input string n, input logic [4:0] bs, input logic s);
    exp_t e;
    e.name = n; e.bs = bs; e.sc = s;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = sb.pop_front();
      if (force_bs !== e.bs || sc !== e.sc) begin
        errors++;
        $display("FAIL %s: got force_bs=%0d sc=%0d, want force_bs=%0d sc=%0d",
                 e.name, force_bs, sc, e.bs, e.sc);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk_sys);
    cart_size = 32'(v.size);
    for (int a = 0; a < v.len; a++) drive(16'(a), gen_byte(v, a));
    idle();
    push_exp(v.name, v.exp_bs, v.exp_sc);
    check_pop();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk("rand4k",        4096,  4096, 0, 40'h0,          0, 0,     0, 5'd0,  1'b0);
    vecs[1]  = mk("e0_8k",         8192,  8192, 0, 40'h8DE01F0000, 3, 'h100, 1, 5'd4,  1'b0);
    vecs[2]  = mk("rand4k_after",  4096,  4096, 0, 40'h0,          0, 0,     0, 5'd0,  1'b0);
    vecs[3]  = mk("plain8k",       8192,  8192, 0, 40'h0,          0, 0,     0, 5'd1,  1'b0);
    vecs[4]  = mk("sc8k",          8192,  8192, 1, 40'h0,          0, 0,     0, 5'd1,  1'b1);
    vecs[5]  = mk("sc8k_diff",     8192,  8192, 2, 40'h0,          0, 0,     0, 5'd1,  1'b0);
    vecs[6]  = mk("e7_16k",        16384, 2048, 0, 40'hADE71F0000, 3, 'h100, 1, 5'd12, 1'b0);
    vecs[7]  = mk("one3f_16k",     16384, 2048, 0, 40'h853F000000, 2, 'h100, 1, 5'd2,  1'b0);
    vecs[8]  = mk("two3f_16k",     16384, 2048, 0, 40'h853F000000, 2, 'h100, 2, 5'd5,  1'b0);
    vecs[9]  = mk("fa_12k",        12288, 1024, 0, 40'h0,          0, 0,     0, 5'd8,  1'b0);
    vecs[10] = mk("p2_10495",      10495, 1024, 0, 40'h0,          0, 0,     0, 5'd7,  1'b0);
    vecs[11] = mk("f0_64k",        65536, 1024, 0, 40'h0,          0, 0,     0, 5'd13, 1'b0);
    vecs[12] = mk("cv_2k",         2048,  2048, 0, 40'h9DFFF30000, 3, 'h100, 1, 5'd9,  1'b0);

    reset = 1'b1; enable = 1'b0; addr = '0; data = '0; cart_size = 32'd4096;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    push_exp("reset_4k", 5'd0, 1'b0);
    check_pop();
    cart_size = 32'd32768;
    #1;
    push_exp("reset_32k", 5'd6, 1'b0);
    check_pop();

    foreach (vecs[i]) run_vec(vecs[i]);

    // 8D E0 before a restart, 1F after it: must not count as E0.
    @(negedge clk_sys);
    cart_size = 32'd8192;
    drive(16'd0, 8'h41); drive(16'd1, 8'h8D); drive(16'd2, 8'hE0);
    drive(16'd0, 8'h1F); drive(16'd1, 8'h41);
    idle();
    push_exp("span_restart", 5'd1, 1'b0);
    check_pop();

    // Signature bytes with enable low must be ignored.
    @(negedge clk_sys); addr = 16'd5; data = 8'h8D;
    @(negedge clk_sys); addr = 16'd6; data = 8'hE0;
    @(negedge clk_sys); addr = 16'd7; data = 8'h1F;
    idle();
    push_exp("enable_low_hold", 5'd1, 1'b0);
    check_pop();

    // E0 image, then reset mid-download, then more bytes without a restart.
    drive(16'd0, 8'h41); drive(16'd1, 8'h8D); drive(16'd2, 8'hE0); drive(16'd3, 8'h1F);
    idle();
    push_exp("pre_reset_e0", 5'd4, 1'b0);
    check_pop();
    @(negedge clk_sys); reset = 1'b1;
    @(negedge clk_sys); reset = 1'b0;
    push_exp("after_reset", 5'd1, 1'b0);
    check_pop();
    drive(16'd10, 8'h85); drive(16'd11, 8'h3F); drive(16'd12, 8'h85); drive(16'd13, 8'h3F);
    idle();
    push_exp("post_reset_3f", 5'd5, 1'b0);
    check_pop();

    // Same 3F flags, different sizes: purely combinational decision.
    cart_size = 32'd32768; #1;
    push_exp("3f_32k", 5'd5, 1'b0);   check_pop();
    cart_size = 32'd65536; #1;
    push_exp("3f_64k", 5'd5, 1'b0);   check_pop();
    cart_size = 32'd5000; #1;
    push_exp("3f_odd", 5'd5, 1'b0);   check_pop();
    cart_size = 32'd1000; #1;
    push_exp("3f_small", 5'd0, 1'b0); check_pop();
    cart_size = 32'd10240; #1;
    push_exp("p2_10k", 5'd7, 1'b0);   check_pop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
